// File: rtl/key_debounce_if.sv
// Key debouncer signal bundle: raw keys in, debounced level and edge strobes out.
// All signals are active-low level / active-high strobe, one bit per key.
interface key_debounce_if #(
  parameter int unsigned N_KEYS = 4
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_db;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;

  modport master (
    output key_raw,
    input  key_db,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  key_raw,
    output key_db,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key debouncer: two-flop synchroniser, then a level must persist for DEBOUNCE_CYCLES
// cycles before key_db follows it; press/release strobes mark each accepted flip.
module key_debounce #(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  localparam int unsigned CNT_W          = $clog2(DEBOUNCE_CYCLES)
) (
  input logic            clk,
  input logic            reset,
  key_debounce_if.slave  bus
);

  typedef enum logic {StStable, StSettling} state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sync1_q, s_q;
  logic [N_KEYS-1:0] key_db_q, key_db_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '1;
      s_q       <= '1;
      key_db_q  <= '1;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= bus.key_raw;
      s_q       <= sync1_q;
      key_db_q  <= key_db_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // State is implied by whether the synchronised key disagrees with the debounced level.
  always_comb begin
    state_e st;
    st        = StStable;
    key_db_d  = key_db_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = '0;
      st       = (s_q[i] == key_db_q[i]) ? StStable : StSettling;
      unique case (st)
        StStable: cnt_d[i] = '0;
        StSettling: begin
          if (cnt_q[i] == CntMax) begin
            key_db_d[i]  = s_q[i];
            press_d[i]   = ~s_q[i];
            release_d[i] = s_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.key_db        = key_db_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_cnt_chk
    cnt_bound_a : assert property (@(posedge clk) disable iff (reset) cnt_q[g] <= CntMax);
  end

endmodule
